// File: rtl/uart_pkg.sv
// Shared UART constants and the receiver state encoding (transmitter uses the same baud default).
package uart_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 10416;
    localparam int DATA_BITS            = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

endpackage

// File: rtl/bit_sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs; 2-cycle latency, no backpressure.
module bit_sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// UART 8N1 receiver: mid-bit sampling, rx_valid HALF_BIT + 9*CLKS_PER_BIT cycles after start
// detection; no backpressure (consumer must take rx_data within one frame time).
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 RxD,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CNT_W    = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_t            state;
    logic [CNT_W-1:0]     baud_cnt;
    logic [2:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;

    bit_sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_rxd_sync (
        .clk   (clk),
        .reset (reset),
        .d     (RxD),
        .q     (rx_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;

            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    if (!rx_s) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end

                // A start bit that is high again at its midpoint is treated as a glitch.
                START: begin
                    if (baud_cnt == HALF_CNT) begin
                        baud_cnt <= '0;
                        if (!rx_s) begin
                            state <= DATA;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (baud_cnt == LAST_CNT) begin
                        baud_cnt  <= '0;
                        shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
                        bit_cnt   <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            state <= STOP;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                // Stop sample lands half a bit before the line's stop bit ends,
                // so a directly following start edge is still caught from IDLE.
                STOP: begin
                    if (baud_cnt == LAST_CNT) begin
                        baud_cnt <= '0;
                        if (rx_s) begin
                            rx_data  <= shift_reg;
                            rx_valid <= 1'b1;
                            state    <= IDLE;
                            busy     <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                BREAK: begin
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Randomised bench for uart_receiver at 16 clocks per bit, checked against a frame-level model.
module tb_uart_receiver;

    localparam int C    = 16;
    localparam int HALF = C / 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       RxD;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // Observed events, collected on the falling edge.
    int         cyc = 0;
    logic [7:0] got_q[$];
    int         fe_cnt      = 0;
    int         both_cnt    = 0;
    int         busy_rise   = -1;
    int         valid_cyc   = -1;
    logic       busy_prev   = 1'b0;

    // Model state: bytes that were framed correctly and the last one delivered.
    logic [7:0] exp_q[$];
    logic [7:0] exp_last;

    uart_receiver #(.CLKS_PER_BIT(C)) dut (
        .clk       (clk),
        .reset     (reset),
        .RxD       (RxD),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid) begin
            got_q.push_back(rx_data);
            valid_cyc = cyc;
        end
        if (frame_err) fe_cnt++;
        if (rx_valid && frame_err) both_cnt++;
        if (busy && !busy_prev) busy_rise = cyc;
        busy_prev = busy;
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: bench did not finish within 60000 cycles");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_bit(input logic v);
        RxD = v;
        repeat (C) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        RxD = 1'b1;
        repeat (n * C) @(negedge clk);
    endtask

    // Line-level frame; the model records the byte only when the stop bit is good.
    task automatic send_frame(input logic [7:0] b, input logic stop_ok);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_ok);
        if (stop_ok) begin
            exp_q.push_back(b);
            exp_last = b;
        end
    endtask

    // Compares everything received since the last call with the model, then clears both.
    task automatic check_rx(input string tag);
        int n;
        check({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({tag, "_byte"}, got_q[i], exp_q[i]);
        check({tag, "_rx_data"}, rx_data, exp_last);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int fe_base;
        logic [7:0] b;

        RxD      = 1'b1;
        reset    = 1'b1;
        exp_last = 8'h00;
        repeat (4) @(negedge clk);
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_rx_valid", rx_valid, 1'b0);
        check("reset_frame_err", frame_err, 1'b0);
        check("reset_busy", busy, 1'b0);
        reset = 1'b0;
        idle_bits(2);

        // 1: single frame and its latency from START entry to rx_valid.
        send_frame(8'hA5, 1'b1);
        idle_bits(1);
        check_rx("t1");
        check("t1_latency", valid_cyc - busy_rise, HALF + 9 * C);
        check("t1_frame_err", fe_cnt, 0);

        // 2: short low glitch is ignored.
        RxD = 1'b0;
        repeat (5) @(negedge clk);
        idle_bits(2);
        check("t2_glitch_busy", busy, 1'b0);
        check_rx("t2_glitch");
        check("t2_frame_err", fe_cnt, 0);
        send_frame(8'h3C, 1'b1);
        idle_bits(1);
        check_rx("t2");

        // 3: bad stop followed by a held-low break.
        fe_base = fe_cnt;
        send_frame(8'h5A, 1'b0);
        repeat (3) drive_bit(1'b0);
        check("t3_busy_in_break", busy, 1'b1);
        idle_bits(1);
        check("t3_busy_after", busy, 1'b0);
        check("t3_frame_err_cnt", fe_cnt - fe_base, 1);
        check_rx("t3_break");
        send_frame(8'h81, 1'b1);
        idle_bits(1);
        check_rx("t3");

        // 4: back-to-back frames with no idle gap.
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle_bits(1);
        check_rx("t4");

        // 5: reset in the middle of data bit 4 of 0x77.
        fe_base = fe_cnt;
        b = 8'h77;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b[i]);
        RxD = b[4];
        repeat (HALF) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t5_rx_data", rx_data, 8'h00);
        check("t5_rx_valid", rx_valid, 1'b0);
        check("t5_frame_err", frame_err, 1'b0);
        check("t5_busy", busy, 1'b0);
        reset    = 1'b0;
        exp_last = 8'h00;
        idle_bits(12);
        check("t5_no_frame_err", fe_cnt - fe_base, 0);
        check_rx("t5_aborted");
        send_frame(8'hC3, 1'b1);
        idle_bits(1);
        check_rx("t5");

        // 6: transmitter-style stream, fixed corners then random bytes and gaps.
        fe_base = fe_cnt;
        for (int i = 0; i < 24; i++) begin
            case (i)
                0:       b = 8'h00;
                1:       b = 8'h55;
                2:       b = 8'hAA;
                3:       b = 8'hFF;
                default: b = 8'($urandom);
            endcase
            send_frame(b, 1'b1);
            RxD = 1'b1;
            repeat ($urandom_range(0, 40)) @(negedge clk);
        end
        idle_bits(1);
        check_rx("t6");
        check("t6_frame_err", fe_cnt - fe_base, 0);
        check("valid_and_err_overlap", both_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
